host_rx_framer: RTL

Byte-to-word framing stage directly upstream of the MMM top level. It accepts the host link's 8-bit byte stream, assembles little-endian 32-bit words, strips frame headers (and optional checksum trailers), and buffers payload words in a small FIFO. Payload words drive the top level's `i_indata` / `i_indata_have` / `o_indata_want` input port. Runs entirely in the 150 MHz domain alongside main_control.

---
 rtl/host_rx_framer_pkg.sv | 27 ++
 rtl/hostrx_word_fifo.sv | 73 +++++++
 rtl/host_rx_framer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/host_rx_framer_pkg.sv
// host_rx_framer_pkg: shared constants, FSM state type and helpers for the
// host receive framer. Honours the HOSTRX_CHECKSUM_EN macro: when defined the
// CSUM state exists, otherwise the FSM only has HDR and PAYLOAD.
package host_rx_framer_pkg;

  localparam logic [15:0] HOSTRX_MAGIC   = 16'h4D4D;
  localparam int          HOSTRX_LENBITS = 16;

`ifdef HOSTRX_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } rx_state_t;
`else
  typedef enum logic {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } rx_state_t;
`endif

  // Saturating 16-bit increment used by the error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hostrx_word_fifo.sv
// hostrx_word_fifo: synchronous 32-bit word FIFO with registered full/empty
// flags and a registered show-ahead read port. rd_data holds the head word
// whenever empty is low. No configuration macros.
module hostrx_word_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_wr;
  logic          do_rd;

  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Occupancy after this cycle's read/write; drives the registered flags.
  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + ONE_COUNT;
      2'b01:   count_next = count - ONE_COUNT;
      default: count_next = count;
    endcase
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, flags and the show-ahead output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr_inc;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
      if (do_rd) begin
        if (count > ONE_COUNT) rd_data <= mem[rd_ptr_inc];
        else if (do_wr)        rd_data <= wr_data;
      end else if (do_wr && empty) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/host_rx_framer.sv
// host_rx_framer: assembles little-endian 32-bit words from the host byte
// stream, strips frame headers, forwards payload words through a FIFO and
// keeps frame/error counters. Macro HOSTRX_CHECKSUM_EN adds a trailing XOR
// checksum word per frame and enables o_err_checksum.
module host_rx_framer
  import host_rx_framer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clk150,
  input  logic        i_reset,
  input  logic [7:0]  i_rxbyte,
  input  logic        i_rxbyte_have,
  output logic        o_rxbyte_want,
  output logic [31:0] o_data,
  output logic        o_data_have,
  input  logic        i_data_want,
  output logic        o_frame_active,
  output logic        o_err_magic,
  output logic        o_err_checksum,
  output logic [15:0] o_frame_count,
  output logic [15:0] o_err_count
);

  rx_state_t                 state;
  rx_state_t                 state_next;
  logic [1:0]                byte_idx;
  logic [23:0]               asm_bytes;
  logic [31:0]               word;
  logic                      word_pending;
  logic                      word_consume;
  logic                      byte_take;
  logic                      fifo_wr;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      hdr_ok;
  logic                      magic_bad;
  logic                      frame_done;
  logic                      err_event;
  logic [HOSTRX_LENBITS-1:0] remain;
`ifdef HOSTRX_CHECKSUM_EN
  logic [31:0]               csum;
  logic                      csum_bad;
`endif

  assign o_rxbyte_want  = !word_pending || word_consume;
  assign byte_take      = i_rxbyte_have && o_rxbyte_want;
  assign o_frame_active = (state != ST_HDR);
  assign o_data_have    = !fifo_empty;
`ifdef HOSTRX_CHECKSUM_EN
  assign err_event      = magic_bad || csum_bad;
`else
  assign err_event      = magic_bad;
  assign o_err_checksum = 1'b0;
`endif

  // Byte assembly: the 4th byte moves the word into the pending slot, which
  // may be freed by a consume in the same cycle.
  always_ff @(posedge i_clk150) begin
    if (i_reset) begin
      byte_idx     <= 2'd0;
      asm_bytes    <= '0;
      word         <= '0;
      word_pending <= 1'b0;
    end else begin
      if (byte_take) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_bytes[7:0]   <= i_rxbyte;
          2'd1:    asm_bytes[15:8]  <= i_rxbyte;
          2'd2:    asm_bytes[23:16] <= i_rxbyte;
          default: word             <= {i_rxbyte, asm_bytes};
        endcase
      end
      if (byte_take && byte_idx == 2'd3) word_pending <= 1'b1;
      else if (word_consume)             word_pending <= 1'b0;
    end
  end

  // Classification FSM state register.
  always_ff @(posedge i_clk150) begin
    if (i_reset) state <= ST_HDR;
    else         state <= state_next;
  end

  // Next-state and per-word decisions for the pending word.
  always_comb begin
    state_next   = state;
    word_consume = 1'b0;
    fifo_wr      = 1'b0;
    hdr_ok       = 1'b0;
    magic_bad    = 1'b0;
    frame_done   = 1'b0;
`ifdef HOSTRX_CHECKSUM_EN
    csum_bad     = 1'b0;
`endif
    case (state)
      ST_HDR: begin
        if (word_pending) begin
          word_consume = 1'b1;
          if (word[31:16] == HOSTRX_MAGIC) begin
            hdr_ok = 1'b1;
            if (word[15:0] != 16'd0) begin
              state_next = ST_PAYLOAD;
            end else begin
`ifdef HOSTRX_CHECKSUM_EN
              state_next = ST_CSUM;
`else
              frame_done = 1'b1;
`endif
            end
          end else begin
            magic_bad = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (word_pending && !fifo_full) begin
          word_consume = 1'b1;
          fifo_wr      = 1'b1;
          if (remain == 16'd1) begin
`ifdef HOSTRX_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_HDR;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef HOSTRX_CHECKSUM_EN
      ST_CSUM: begin
        if (word_pending) begin
          word_consume = 1'b1;
          frame_done   = 1'b1;
          csum_bad     = (word != csum);
          state_next   = ST_HDR;
        end
      end
`endif
      default: state_next = ST_HDR;
    endcase
  end

  // Payload length down-counter, loaded from each accepted header.
  always_ff @(posedge i_clk150) begin
    if (i_reset)      remain <= '0;
    else if (hdr_ok)  remain <= word[15:0];
    else if (fifo_wr) remain <= remain - 16'd1;
  end

`ifdef HOSTRX_CHECKSUM_EN
  // Running XOR of the current frame's payload words.
  always_ff @(posedge i_clk150) begin
    if (i_reset)      csum <= '0;
    else if (hdr_ok)  csum <= '0;
    else if (fifo_wr) csum <= csum ^ word;
  end

  // Checksum error pulse, aligned with the error counter update.
  always_ff @(posedge i_clk150) begin
    if (i_reset) o_err_checksum <= 1'b0;
    else         o_err_checksum <= csum_bad;
  end
`endif

  // Frame counter wraps; error counter saturates; magic pulse is one cycle.
  always_ff @(posedge i_clk150) begin
    if (i_reset) begin
      o_frame_count <= '0;
      o_err_count   <= '0;
      o_err_magic   <= 1'b0;
    end else begin
      o_err_magic <= magic_bad;
      if (frame_done) o_frame_count <= o_frame_count + 16'd1;
      if (err_event)  o_err_count   <= sat_inc16(o_err_count);
    end
  end

  hostrx_word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk150),
    .reset   (i_reset),
    .wr_en   (fifo_wr),
    .wr_data (word),
    .rd_en   (i_data_want),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
